seq_mul_arbiter: RTL and testbench
==================================

SEQ_MUL_ARBITER -- requirements
Module: seq_mul_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width in bits; product width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port req0  input  1  requester 0 multiply request, level.
REQ-005 SHALL have port a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 SHALL have port req1  input  1  requester 1 multiply request, level.
REQ-007 SHALL have port a1, b1  input  WIDTH each  requester 1 operands.
REQ-008 SHALL have port gnt0, gnt1  output  1 each  one-cycle grant pulse; operands of that requester latched.
REQ-009 SHALL have port done0, done1  output  1 each  one-cycle completion pulse; product valid.
REQ-010 SHALL have port busy  output  1  high from grant cycle through done cycle inclusive.
REQ-011 SHALL have port product  output  2*WIDTH  unsigned result of the last completed job.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-013 In IDLE at edge k with req0 or req1 high: SHALL select a winner, latch its a/b into la/lb, clear accumulator and bit counter, assert winner's gnt for the cycle after edge k, set busy, enter RUN.
REQ-014 Arbitration SHALL be round-robin: single requester wins; with both high, the requester not served last wins; last-served pointer resets to requester 1 so requester 0 wins the first tie.
REQ-015 In RUN, each edge SHALL add (la[cnt] ? lb << cnt : 0) into a 2*WIDTH accumulator and increment cnt; after cnt = WIDTH-1 is processed, enter DONE.
REQ-016 Latency SHALL be fixed regardless of operand values: WIDTH RUN edges (k+1..k+WIDTH); with WIDTH=6, done pulse is high in the cycle after edge k+7.
REQ-017 On entering DONE, product SHALL load the accumulator value, and done0/done1 of the granted requester SHALL pulse for exactly one cycle.
REQ-018 DONE SHALL return to IDLE on the next edge; req inputs are ignored in DONE and RUN; earliest next grant at edge k+8.
REQ-019 product SHALL hold its value until the next DONE entry; it does not change on grant or during RUN.
REQ-020 Operand inputs SHALL be sampled only at the grant edge; later changes on a/b have no effect on the running job.
REQ-021 Requester SHALL hold req high until its done pulse and drop it in the done cycle; a req still high in IDLE after done is treated as a new request.
REQ-022 gnt0/gnt1 and done0/done1 SHALL never be high simultaneously; at most one gnt and one done per job.
REQ-023 Accumulator SHALL be 2*WIDTH bits wide; no overflow is possible for unsigned WIDTH x WIDTH.

Reset
REQ-024 rst low SHALL immediately, without waiting for clk, force state IDLE, cnt 0, accumulator 0, product 0, gnt0/gnt1/done0/done1/busy 0, last-served pointer to requester 1.
REQ-025 rst low mid-RUN SHALL abandon the job with no done pulse; after rst returns high, the first edge with a req high starts a fresh arbitration.
REQ-026 Operand latches la/lb SHALL reset to 0.

Verification
REQ-027 Single job: req0=1, a0=63, b0=63 at edge k -> gnt0 after k, busy high, done0 after k+7, product=3969, done1/gnt1 never high.
REQ-028 Tie after reset: req0=req1=1, a0=5,b0=7, a1=12,b1=10 -> gnt0 first, done0 with product=35; requester 0 drops req0; next grant gnt1 at k+8, done1 with product=120.
REQ-029 Fairness: req0 and req1 held continuously (re-raised after each done) -> grants alternate 0,1,0,1 over four jobs, each job 8 cycles apart.
REQ-030 Zero/boundary operands: a1=0, b1=63 -> done1 at same fixed latency, product=0; then a0=1, b0=63 -> product=63.
REQ-031 Reset mid-job: req0 job granted, rst low at edge k+3 for 2 cycles -> all outputs 0 asynchronously, no done0; after release, req1 with a1=2,b1=3 -> gnt1, done1, product=6.
REQ-032 Operand change during RUN: grant with a0=9,b0=9, then change a0/b0 to 0 -> product=81.

Source files
------------

// File: rtl/seq_mul_arbiter.sv
// seq_mul_arbiter: a shift-and-add multiplier shared by two requesters.
// A round-robin arbiter picks one requester at a time. The winner's operands
// are latched, the product is built one multiplier bit per clock, and the
// winner gets a grant pulse and later a done pulse. Every job takes the same
// number of cycles, whatever the operand values.
module seq_mul_arbiter #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;

    logic             r_last;
    logic             r_owner;
    logic [WIDTH-1:0] r_la;
    logic [WIDTH-1:0] r_lb;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;

    logic             w_anyReq;
    logic             w_winner;
    logic             w_grant;
    logic             w_lastBit;
    logic             w_finish;
    logic [PW-1:0]    w_partial;

    // On a tie, the requester that was not served last wins. A lone requester always wins.
    assign w_anyReq  = req0 | req1;
    assign w_winner  = (req0 & req1) ? ~r_last : ~req0;
    assign w_lastBit = (r_cnt == CW'(WIDTH - 1));
    assign w_partial = r_la[r_cnt] ? (PW'(r_lb) << r_cnt) : '0;

    // Next-state logic. Requests are only looked at in IDLE.
    always_comb begin
        w_stateNext = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_grant     = 1'b1;
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (w_lastBit) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_finish    = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register. An asynchronous reset abandons any job that is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath: latch operands at the grant, add one partial product per RUN cycle, publish the result in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_la    <= '0;
            r_lb    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            product <= '0;
        end else begin
            if (w_grant) begin
                r_la    <= w_winner ? a1 : a0;
                r_lb    <= w_winner ? b1 : b0;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_owner <= w_winner;
                r_last  <= w_winner;
            end
            if (r_state == RUN) begin
                r_acc <= r_acc + w_partial;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                product <= r_acc;
            end
        end
    end

    // Registered handshake outputs. busy also covers the done cycle, even though the FSM is already back in IDLE then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
        end else begin
            gnt0  <= w_grant & ~w_winner;
            gnt1  <= w_grant & w_winner;
            done0 <= w_finish & ~r_owner;
            done1 <= w_finish & r_owner;
            busy  <= (w_stateNext != IDLE) | w_finish;
        end
    end

endmodule

// File: tb/tb_seq_mul_arbiter.sv
// tb_seq_mul_arbiter: directed checks of the grant and done timing, the products,
// round-robin order, reset behaviour and operand isolation, with expected values
// worked out by hand.
module tb_seq_mul_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [5:0]  a0;
    logic [5:0]  b0;
    logic        req1;
    logic [5:0]  a1;
    logic [5:0]  b1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        busy;
    logic [11:0] product;

    int total = 0;
    int bad   = 0;

    seq_mul_arbiter #(.WIDTH(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .busy    (busy),
        .product (product)
    );

    // Free-running clock with a 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [5:0] x0, input logic [5:0] y0,
                                 input logic r1, input logic [5:0] x1, input logic [5:0] y1);
        req0 = r0;
        a0   = x0;
        b0   = y0;
        req1 = r1;
        a1   = x1;
        b1   = y1;
    endtask

    // Runs one job starting from a negedge, with the requests already driven.
    // It checks the grant cycle, the six quiet cycles and the done cycle.
    task automatic runJob(input int winner, input int expProd, input int prevProd,
                          input bit dropReq, input bit zeroOps);
        logic [1:0] oneHot;
        oneHot = (winner == 1) ? 2'b10 : 2'b01;
        @(posedge clk);
        @(negedge clk);
        checkOutput("grant", 32'({gnt1, gnt0}), 32'(oneHot));
        checkOutput("grant_busy", 32'(busy), 1);
        checkOutput("grant_prod_hold", 32'(product), prevProd);
        if (zeroOps) begin
            a0 = '0;
            b0 = '0;
            a1 = '0;
            b1 = '0;
        end
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("run_quiet", 32'({gnt1, gnt0, done1, done0}), 0);
            checkOutput("run_busy", 32'(busy), 1);
            checkOutput("run_prod_hold", 32'(product), prevProd);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("done", 32'({done1, done0}), 32'(oneHot));
        checkOutput("done_gnt", 32'({gnt1, gnt0}), 0);
        checkOutput("done_busy", 32'(busy), 1);
        checkOutput("product", 32'(product), expProd);
        if (dropReq) begin
            if (winner == 1) req1 = 1'b0;
            else             req0 = 1'b0;
        end
    endtask

    initial begin
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outs", 32'({gnt0, gnt1, done0, done1, busy}), 0);
        checkOutput("reset_prod", 32'(product), 0);
        rst = 1'b1;

        // Tie straight after reset: requester 0 wins first, then requester 1.
        applyStimulus(1'b1, 6'd5, 6'd7, 1'b1, 6'd12, 6'd10);
        runJob(0, 35, 0, 1'b1, 1'b0);
        runJob(1, 120, 35, 1'b1, 1'b0);

        // Single job with full-scale operands, followed by an idle cycle.
        applyStimulus(1'b1, 6'd63, 6'd63, 1'b0, 6'd0, 6'd0);
        runJob(0, 3969, 120, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_gnt", 32'({gnt1, gnt0}), 0);
        checkOutput("idle_prod", 32'(product), 3969);

        // Boundary operands: a zero multiplier, then a multiplier of one.
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, 6'd0, 6'd63);
        runJob(1, 0, 3969, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'd1, 6'd63, 1'b0, 6'd0, 6'd0);
        runJob(0, 63, 0, 1'b1, 1'b0);

        // Operands change after the grant and must not affect the job.
        applyStimulus(1'b1, 6'd9, 6'd9, 1'b0, 6'd0, 6'd0);
        runJob(0, 81, 63, 1'b1, 1'b1);

        // Reset in the middle of a job: outputs clear at once and no done pulse appears.
        applyStimulus(1'b1, 6'd9, 6'd5, 1'b0, 6'd0, 6'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_grant", 32'({gnt1, gnt0}), 1);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_async_outs", 32'({gnt0, gnt1, done0, done1, busy}), 0);
        checkOutput("mid_async_prod", 32'(product), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("mid_held", 32'({done1, done0, busy}), 0);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, 6'd2, 6'd3);
        runJob(1, 6, 0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_done0", 32'(done0), 0);

        // Both requests held continuously: grants alternate 0,1,0,1 with jobs 8 cycles apart.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 6'd3, 6'd4, 1'b1, 6'd7, 6'd11);
        runJob(0, 12, 0, 1'b0, 1'b0);
        runJob(1, 77, 12, 1'b0, 1'b0);
        runJob(0, 12, 77, 1'b0, 1'b0);
        runJob(1, 77, 12, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
